// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - BFloat16 format constants and packed word type
package bf16_pkg;

  localparam int BF16_EXP_W   = 8;
  localparam int BF16_FRAC_W  = 7;
  localparam int BF16_BIAS    = 127;
  localparam int BF16_EXP_MAX = 255;

  typedef struct packed {
    logic                   sign;
    logic [BF16_EXP_W-1:0]  exp;
    logic [BF16_FRAC_W-1:0] frac;
  } bf16_t;

endpackage

// File: rtl/lzc.sv
// rtl/lzc.sv - leading-zero counter, returns W for an all-zero input
module lzc #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  // Scanning upward lets the highest set bit overwrite every lower one.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/bf16_norm.sv
// rtl/bf16_norm.sv - two-stage BF16 normalize-and-pack, optional RNE via BF16_NORM_ROUND_EN
module bf16_norm
  import bf16_pkg::*;
#(
  parameter int M_W = 16,
  parameter int E_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic           sign_i,
  input  logic [E_W-1:0] exp_i,
  input  logic [M_W-1:0] mant_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [15:0]    res_o,
  output logic           of_o,
  output logic           uf_o
);

  localparam int LZ_W = $clog2(M_W + 1);

  logic [LZ_W-1:0] lz_in;
  logic            s1_v, s1_sign;
  logic [E_W-1:0]  s1_exp;
  logic [M_W-1:0]  s1_mant;
  logic [LZ_W-1:0] s1_lz;

  logic            s2_v, s2_of, s2_uf;
  bf16_t           s2_res;

  logic            s1_load, s2_load;

  lzc #(.W(M_W)) u_lzc (
    .din (mant_i),
    .cnt (lz_in)
  );

  assign ready_o = ~s1_v | ~s2_v | ready_i;
  assign s1_load = valid_i & ready_o;
  assign s2_load = s1_v & (~s2_v | ready_i);

  // Exponent of the normalized value; one wider than the input so overflow and
  // underflow stay distinguishable by sign.
  logic [E_W:0] e_base, e_fin;
  logic [6:0]   frac;
  logic         nz;

  assign e_base = {s1_exp[E_W-1], s1_exp} + (E_W+1)'(1) - (E_W+1)'(s1_lz);

`ifdef BF16_NORM_ROUND_EN
  logic [M_W-1:0] n;
  logic           guard, sticky, rnd;
  logic [7:0]     frac_inc;

  assign n        = s1_mant << s1_lz;
  assign guard    = n[M_W-9];
  assign sticky   = |n[M_W-10:0];
  assign rnd      = guard & (sticky | n[M_W-8]);
  assign frac_inc = {1'b0, n[M_W-2 -: 7]} + 8'(rnd);
  assign nz       = n[M_W-1];
  assign frac     = frac_inc[6:0];
  assign e_fin    = e_base + (E_W+1)'(frac_inc[7]);
`else
  logic [7:0] n_top;

  assign n_top = 8'((s1_mant << s1_lz) >> (M_W - 8));
  assign nz    = n_top[7];
  assign frac  = n_top[6:0];
  assign e_fin = e_base;
`endif

  logic  e_le0, e_ge_max;
  bf16_t nxt_res;
  logic  nxt_of, nxt_uf;

  assign e_le0    = e_fin[E_W] | (e_fin == '0);
  assign e_ge_max = ~e_fin[E_W] & (e_fin >= (E_W+1)'(BF16_EXP_MAX));

  // A nonzero mantissa always normalizes with its leading one at the MSB.
  always_comb begin
    nxt_res      = '0;
    nxt_res.sign = s1_sign;
    nxt_of       = 1'b0;
    nxt_uf       = 1'b0;
    if (nz && e_le0) begin
      nxt_uf = 1'b1;
    end else if (nz && e_ge_max) begin
      nxt_res.exp = '1;
      nxt_of      = 1'b1;
    end else if (nz) begin
      nxt_res.exp  = e_fin[7:0];
      nxt_res.frac = frac;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_mant <= '0;
      s1_lz   <= '0;
      s2_v    <= 1'b0;
      s2_res  <= '0;
      s2_of   <= 1'b0;
      s2_uf   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_v    <= 1'b1;
        s1_sign <= sign_i;
        s1_exp  <= exp_i;
        s1_mant <= mant_i;
        s1_lz   <= lz_in;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end

      if (s2_load) begin
        s2_v   <= 1'b1;
        s2_res <= nxt_res;
        s2_of  <= nxt_of;
        s2_uf  <= nxt_uf;
      end else if (ready_i) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign valid_o = s2_v;
  assign res_o   = s2_res;
  assign of_o    = s2_of;
  assign uf_o    = s2_uf;

endmodule

// File: tb/tb_bf16_norm.sv
// tb/tb_bf16_norm.sv - scoreboard bench for bf16_norm with directed vectors
module tb_bf16_norm;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic        sign_i;
  logic [9:0]  exp_i;
  logic [15:0] mant_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] res_o;
  logic        of_o;
  logic        uf_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_q[$];

  bf16_norm #(.M_W(16), .E_W(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sign_i  (sign_i),
    .exp_i   (exp_i),
    .mant_i  (mant_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res_o   (res_o),
    .of_o    (of_o),
    .uf_o    (uf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Presents one triple and pushes its expected result once the handshake is due.
  task automatic send(input logic s, input logic [9:0] e, input logic [15:0] m,
                      input logic [15:0] r, input logic of, input logic uf);
    int waited = 0;
    @(negedge clk);
    sign_i  = s;
    exp_i   = e;
    mant_i  = m;
    valid_i = 1'b1;
    while (!ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: ready_o stuck at 0 for mant %h", m);
    end else begin
      exp_q.push_back({r, of, uf});
    end
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  logic        held = 1'b0;
  logic [17:0] held_val;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) check("stall_hold", {14'h0, res_o, of_o, uf_o}, {14'h0, held_val});
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", res_o);
        end else begin
          check("result", {14'h0, res_o, of_o, uf_o}, {14'h0, exp_q.pop_front()});
        end
      end
      held     = valid_o && !ready_i;
      held_val = {res_o, of_o, uf_o};
    end
  end

`ifdef BF16_NORM_ROUND_EN
  localparam logic [15:0] RND_RES   = 16'h3F82;
  localparam logic [15:0] RCARRY    = 16'h7F80;
  localparam logic        RCARRY_OF = 1'b1;
`else
  localparam logic [15:0] RND_RES   = 16'h3F81;
  localparam logic [15:0] RCARRY    = 16'h7F7F;
  localparam logic        RCARRY_OF = 1'b0;
`endif

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    sign_i  = 1'b0;
    exp_i   = '0;
    mant_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_ready_o", 32'(ready_o), 32'd1);
    check("reset_res_o",   32'(res_o),   32'd0);
    check("reset_flags",   {30'h0, of_o, uf_o}, 32'd0);
    rst = 1'b0;

    // Latency: accepted at edge k, visible after edge k+1.
    send(1'b0, 10'd127, 16'h4000, 16'h3F80, 1'b0, 1'b0);
    check("latency_early", 32'(valid_o), 32'd0);
    @(posedge clk);
    #1 check("latency_2cyc", 32'(valid_o), 32'd1);

    send(1'b0, 10'd127, 16'h8000, 16'h4000, 1'b0, 1'b0);
    send(1'b0, 10'd254, 16'h8000, 16'h7F80, 1'b1, 1'b0);
    send(1'b0, 10'd10,  16'h0001, 16'h0000, 1'b0, 1'b1);
    send(1'b1, 10'd127, 16'h0000, 16'h8000, 1'b0, 1'b0);
    send(1'b0, 10'd127, 16'h40C0, RND_RES,  1'b0, 1'b0);
    send(1'b1, 10'd127, 16'h6000, 16'hBFC0, 1'b0, 1'b0);
    send(1'b0, 10'd0,   16'h4000, 16'h0000, 1'b0, 1'b1);
    send(1'b0, 10'd1,   16'h4000, 16'h0080, 1'b0, 1'b0);
    send(1'b0, 10'h3FF, 16'h8000, 16'h0000, 1'b0, 1'b1);
    send(1'b0, 10'd254, 16'h7F80, 16'h7F7F, 1'b0, 1'b0);
    send(1'b0, 10'd254, 16'h7FC0, RCARRY,   RCARRY_OF, 1'b0);
    send(1'b0, 10'd127, 16'h4040, 16'h3F80, 1'b0, 1'b0);

    // Backpressure: four back-to-back inputs while the sink stalls.
    @(posedge clk);
    #1 ready_i = 1'b0;
    fork
      begin
        send(1'b0, 10'd127, 16'h4000, 16'h3F80, 1'b0, 1'b0);
        send(1'b0, 10'd127, 16'h8000, 16'h4000, 1'b0, 1'b0);
        send(1'b0, 10'd128, 16'h8000, 16'h4080, 1'b0, 1'b0);
        send(1'b0, 10'd126, 16'h4000, 16'h3F00, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_ready_low", 32'(ready_o), 32'd0);
        @(negedge clk);
        check("bp_ready_low2", 32'(ready_o), 32'd0);
        @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    repeat (4) @(posedge clk);

    // Reset with both stages full: nothing queued before it may emerge.
    #1 ready_i = 1'b0;
    send(1'b0, 10'd127, 16'h4000, 16'h3F80, 1'b0, 1'b0);
    send(1'b0, 10'd128, 16'h4000, 16'h4000, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("pre_reset_full", {31'h0, valid_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    check("post_reset_valid", 32'(valid_o), 32'd0);
    ready_i = 1'b1;
    send(1'b0, 10'd128, 16'h6000, 16'h4040, 1'b0, 1'b0);

    begin
      int guard_cnt = 0;
      while (exp_q.size() != 0 && guard_cnt < 100) begin
        @(posedge clk);
        guard_cnt++;
      end
    end
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
